subtree_fanin_merger: RTL
=========================

Name: subtree_fanin_merger

Overview:
- Fan-in counterpart to the one-to-five instance fan-out used by the generated subtree roots.
- Merges NUM_CH child valid/ready streams into one upstream stream using round-robin arbitration.
- Each output beat is tagged with its source child index.
- Sits directly above a subtree's child instances and returns child results toward the root.

Parameters:
- NUM_CH, 5, number of child input channels (2..8).
- DATA_W, 8, payload width per channel.
- SRC_W, 3, width of source index; must satisfy 2^SRC_W >= NUM_CH.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  NUM_CH  per-child valid.
- in_data  in  NUM_CH*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-child ready; one-hot or zero.
- out_valid  out  1  upstream beat valid.
- out_data  out  DATA_W  upstream payload.
- out_src  out  SRC_W  child index of the current beat.
- out_ready  in  1  upstream ready.
- beat_cnt  out  CNT_W  count of completed upstream handshakes.

Behaviour:
- Reset (synchronous, active-low): sampled at a clk edge with rst_n=0, it sets:
  - out_valid=0, out_data=0, out_src=0
  - beat_cnt=0, rr_ptr=0
  - state=EMPTY
  - Any held beat is discarded. in_ready is 0 while rst_n=0.
- State machine (single output register):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: load_en = (state==EMPTY) || (out_ready && out_valid).
  - Upstream consume and a new load may occur in the same cycle, giving a sustained rate of 1 beat/clk.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - grant = the first index i with in_valid[i]=1.
  - No valid input means no grant.
- Ready: in_ready[i] = load_en && grant==i. A child transfer occurs when in_valid[i] && in_ready[i].
- On a child transfer at an edge:
  - out_data <= in_data slice i; out_src <= i; out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_CH, with explicit wrap at NUM_CH-1, not at 2^SRC_W.
- Upstream handshake (out_valid && out_ready) with no simultaneous load: out_valid <= 0 and state goes to EMPTY. out_data and out_src keep their last values.
- No child transfer: rr_ptr is unchanged.
- Latency: 1 cycle from child handshake to out_valid.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_src are stable and every in_ready=0.
- beat_cnt increments by 1 on each upstream handshake and wraps from 2^CNT_W-1 to 0.
- Fairness: with all NUM_CH children continuously valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0 with no repeats inside a window of NUM_CH beats.
- Boundaries:
  - A child that drops in_valid before being granted is skipped with no penalty.
  - in_valid asserted during reset is ignored.
  - Reset mid-backpressure discards the held beat. No upstream handshake is counted for it.
  - in_data of non-granted children is ignored.
  - The arbiter produces at most one grant per cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with in_valid=5'b11111 -> in_ready=0, out_valid=0, beat_cnt=0. First grant after release goes to child 0.
- Round-robin: all five children valid with data 0x10+i, out_ready=1, for 10 cycles -> out_src sequence 0,1,2,3,4,0,1,2,3,4, out_data matches, one beat per clk, beat_cnt=10.
- Sparse and wrap:
  - Only child 3 valid -> granted, rr_ptr=4.
  - Then children 1 and 4 valid -> order 4 then 1, showing the pointer wraps at 4 to 0.
- Backpressure: child 2 sends 0xAB, out_ready=0 for 4 cycles -> out_valid=1, out_data=0xAB, out_src=2 stable, in_ready=0. Raise out_ready -> handshake, beat_cnt+1, next beat appears on the following clk.
- Reset mid-operation: beat 0x55 held under backpressure, rst_n=0 for 1 clk -> out_valid=0, beat_cnt=0, rr_ptr=0. No phantom beat after release.
- Counter wrap: CNT_W=4, send 17 beats -> beat_cnt reads 15 then 0 then 1.

Source files
------------

// File: rtl/subtree_fanin_merger.sv
// Round-robin fan-in of NUM_CH child valid/ready streams into one registered upstream
// stream, with each beat tagged by the index of the child that produced it.
module subtree_fanin_merger #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int SRC_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         beat_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                loadEn;
  logic                upHandshake;
  logic                grantValid;
  logic [SRC_W-1:0]    grantIdx;
  logic                xfer;

  // Pointer is always below NUM_CH, so one conditional subtraction wraps at NUM_CH, not 2^SRC_W.
  function automatic logic [SRC_W-1:0] scanIdx(input logic [SRC_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end
    return SRC_W'(sum);
  endfunction

  assign out_valid   = (state_q == FULL);
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign beat_cnt    = cnt_q;
  assign upHandshake = out_valid && out_ready;
  assign loadEn      = (state_q == EMPTY) || upHandshake;
  assign xfer        = rst_n && loadEn && grantValid;

  // Scan from farthest to nearest offset so the child closest to the pointer wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (in_valid[scanIdx(ptr_q, k)]) begin
        grantValid = 1'b1;
        grantIdx   = scanIdx(ptr_q, k);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q + CNT_W'(upHandshake);
    if (xfer) begin
      state_d = FULL;
      data_d  = in_data[grantIdx*DATA_W +: DATA_W];
      src_d   = grantIdx;
      ptr_d   = (grantIdx == SRC_W'(NUM_CH - 1)) ? '0 : grantIdx + 1'b1;
    end else if (upHandshake) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
